// File: rtl/cond_pkg.sv
// Shared constants for the input-conditioning blocks that clean up raw
// asynchronous inputs before they reach synchronous logic.
package cond_pkg;

    localparam int   DEFAULT_STABLE_CYCLES = 4;
    localparam logic LEVEL_LOW             = 1'b0;
    localparam logic LEVEL_HIGH            = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Plain two-stage synchroniser for one asynchronous bit; both stages reset to INIT.
module sync_2ff
    import cond_pkg::*;
#(
    parameter logic INIT = LEVEL_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= INIT;
            r_s2 <= INIT;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/input_conditioner.sv
// Debounces a raw asynchronous input into a clean registered level and emits
// one-clock rise/fall pulses when that level changes.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic INIT_LEVEL    = LEVEL_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic dout,
    output logic rise_p,
    output logic fall_p,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s2;
    logic             r_dout;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    sync_2ff #(
        .INIT (INIT_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din_raw),
        .q     (w_s2)
    );

    // Any agreement between the synchronised input and dout restarts the count,
    // so only an uninterrupted run of STABLE_CYCLES disagreements flips dout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= INIT_LEVEL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s2 == r_dout) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_dout <= w_s2;
                r_cnt  <= '0;
                r_rise <= w_s2;
                r_fall <= ~w_s2;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign dout   = r_dout;
    assign rise_p = r_rise;
    assign fall_p = r_fall;
    assign busy   = (r_cnt != '0);

endmodule

// File: tb/tb_input_conditioner.sv
// Cycle-by-cycle vector bench for input_conditioner (STABLE_CYCLES=4, INIT_LEVEL=0).
module tb_input_conditioner;

    typedef struct {
        string tag;
        logic  rst_n;
        logic  din;
        logic  dout;
        logic  rise;
        logic  fall;
        logic  busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic din_raw;
    logic dout;
    logic rise_p;
    logic fall_p;
    logic busy;
    logic q_ff;

    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    vec_t sb[$];

    always #10 clk = ~clk;

    // Stand-in for the downstream D flip-flop fed by dout.
    always_ff @(posedge clk) q_ff <= dout;

    input_conditioner #(
        .STABLE_CYCLES (4),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_raw (din_raw),
        .dout    (dout),
        .rise_p  (rise_p),
        .fall_p  (fall_p),
        .busy    (busy)
    );

    task automatic add_n(input int n, input string tag, input logic r, input logic d,
                         input logic o, input logic ri, input logic f, input logic b);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.tag = tag; v.rst_n = r; v.din = d;
            v.dout = o; v.rise = ri; v.fall = f; v.busy = b;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input int step, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b, expected %b", name, step, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t exp_v;
        logic prev_dout;

        // fields: count, tag, rst_n, din_raw | expected dout, rise_p, fall_p, busy
        add_n(3, "reset",     0, 1, 0, 0, 0, 0);
        add_n(3, "idle",      1, 0, 0, 0, 0, 0);
        // clean rising step: flip 5 edges after capture, busy the 3 cycles before
        add_n(2, "rise",      1, 1, 0, 0, 0, 0);
        add_n(3, "rise",      1, 1, 0, 0, 0, 1);
        add_n(1, "rise",      1, 1, 1, 1, 0, 0);
        add_n(4, "rise",      1, 1, 1, 0, 0, 0);
        // clean falling step
        add_n(2, "fall",      1, 0, 1, 0, 0, 0);
        add_n(3, "fall",      1, 0, 1, 0, 0, 1);
        add_n(1, "fall",      1, 0, 0, 0, 1, 0);
        add_n(4, "fall",      1, 0, 0, 0, 0, 0);
        // bounce 1,1,0 then steady 1: count restarts once s2 dips back
        add_n(2, "bounce",    1, 1, 0, 0, 0, 0);
        add_n(1, "bounce",    1, 0, 0, 0, 0, 1);
        add_n(1, "bounce",    1, 1, 0, 0, 0, 1);
        add_n(1, "bounce",    1, 1, 0, 0, 0, 0);
        add_n(3, "bounce",    1, 1, 0, 0, 0, 1);
        add_n(1, "bounce",    1, 1, 1, 1, 0, 0);
        add_n(3, "bounce",    1, 1, 1, 0, 0, 0);
        // back to 0, then start a rising count and reset it at cnt==2
        add_n(2, "fall2",     1, 0, 1, 0, 0, 0);
        add_n(3, "fall2",     1, 0, 1, 0, 0, 1);
        add_n(1, "fall2",     1, 0, 0, 0, 1, 0);
        add_n(2, "fall2",     1, 0, 0, 0, 0, 0);
        add_n(2, "midrst",    1, 1, 0, 0, 0, 0);
        add_n(2, "midrst",    1, 1, 0, 0, 0, 1);
        add_n(1, "midrst",    0, 1, 0, 0, 0, 0);
        add_n(2, "postrst",   1, 1, 0, 0, 0, 0);
        add_n(3, "postrst",   1, 1, 0, 0, 0, 1);
        add_n(1, "postrst",   1, 1, 1, 1, 0, 0);
        add_n(2, "postrst",   1, 1, 1, 0, 0, 0);
        // one-clock low glitch every 5 clocks: only a one-cycle busy blip, two edges later
        for (int k = 0; k < 100; k++)
            add_n(1, "glitch", 1, (k % 5 == 2) ? 1'b0 : 1'b1, 1, 0, 0, (k % 5 == 4) ? 1'b1 : 1'b0);

        rst_n   = 1'b0;
        din_raw = 1'b0;
        prev_dout = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            din_raw = vecs[i].din;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard step %0d: got empty queue, expected an entry", i);
            end else begin
                exp_v = sb.pop_front();
                check({exp_v.tag, ".dout"}, i, dout,   exp_v.dout);
                check({exp_v.tag, ".rise"}, i, rise_p, exp_v.rise);
                check({exp_v.tag, ".fall"}, i, fall_p, exp_v.fall);
                check({exp_v.tag, ".busy"}, i, busy,   exp_v.busy);
                if (i > 0)
                    check({exp_v.tag, ".q"}, i, q_ff, prev_dout);
                prev_dout = exp_v.dout;
                $display("step %0d %s: rst_n=%b din=%b -> dout=%b rise=%b fall=%b busy=%b",
                         i, exp_v.tag, exp_v.rst_n, exp_v.din, dout, rise_p, fall_p, busy);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
